// File: rtl/td4_pkg.sv
// td4_pkg: shared opcode encodings, default widths and run-state type for the TD4 family.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package td4_pkg;

  localparam int DATA_W_DEF = 4;
  localparam int ADDR_W_DEF = 4;
  localparam int OP_W       = 4;

  // Encodings match the original TD4 so legacy program images run unchanged.
  typedef enum logic [OP_W-1:0] {
    OP_ADD_A    = 4'b0000,
    OP_MOV_A_B  = 4'b0001,
    OP_IN_A     = 4'b0010,
    OP_MOV_A_IM = 4'b0011,
    OP_MOV_B_A  = 4'b0100,
    OP_ADD_B    = 4'b0101,
    OP_IN_B     = 4'b0110,
    OP_MOV_B_IM = 4'b0111,
    OP_HALT     = 4'b1000,
    OP_OUT_B    = 4'b1001,
    OP_JC       = 4'b1010,
    OP_OUT_IM   = 4'b1011,
    OP_NOP0     = 4'b1100,
    OP_NOP1     = 4'b1101,
    OP_JNC      = 4'b1110,
    OP_JMP      = 4'b1111
  } opcode_t;

  typedef enum logic {
    ST_RUN  = 1'b0,
    ST_HALT = 1'b1
  } run_state_t;

  // Only the two ADD opcodes feed the immediate into the adder.
  function automatic logic is_add(input opcode_t op);
    return (op == OP_ADD_A) || (op == OP_ADD_B);
  endfunction

endpackage

// File: rtl/td4_alu.sv
// td4_alu: DATA_W-bit adder producing wrapped result and carry-out.
// Latency: combinational.
// Backpressure: none; ports: src, addend in -> result, carry out.
module td4_alu #(
  parameter int DATA_W = 4
) (
  input  logic [DATA_W-1:0] src,
  input  logic [DATA_W-1:0] addend,
  output logic [DATA_W-1:0] result,
  output logic              carry
);

  logic [DATA_W:0] sum;

  assign sum    = {1'b0, src} + {1'b0, addend};
  assign result = sum[DATA_W-1:0];
  assign carry  = sum[DATA_W];

endmodule

// File: rtl/td4_core_param.sv
// td4_core_param: parametrised TD4 accumulator core with fetch wait states, HALT and JC.
// Latency: one instruction per CLK edge when D_VALID=1; A follows PC combinationally.
// Backpressure: D_VALID=0 stalls all state; HALTED freezes everything until CLR.
// Ports: CLK/CLR (async active-low), A/D/D_VALID program memory, IN/OUT board I/O,
//        CARRY flag, HALTED status.
module td4_core_param
  import td4_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic                   CLK,
  input  logic                   CLR,
  output logic [ADDR_W-1:0]      A,
  input  logic [OP_W+DATA_W-1:0] D,
  input  logic                   D_VALID,
  input  logic [DATA_W-1:0]      IN,
  output logic [DATA_W-1:0]      OUT,
  output logic                   CARRY,
  output logic                   HALTED
);

  opcode_t           op;
  logic [DATA_W-1:0] imm;

  assign op  = opcode_t'(D[OP_W+DATA_W-1:DATA_W]);
  assign imm = D[DATA_W-1:0];

  logic [ADDR_W-1:0] pc, pc_nxt;
  logic [DATA_W-1:0] a_reg, a_nxt;
  logic [DATA_W-1:0] b_reg, b_nxt;
  logic [DATA_W-1:0] out_reg, out_nxt;
  logic              carry_q, carry_nxt;
  run_state_t        state, state_nxt;

  logic              exec;
  logic [DATA_W-1:0] alu_src, alu_addend, alu_result;
  logic              alu_carry;

  // An instruction executes only on a valid fetch while running.
  assign exec = D_VALID && (state == ST_RUN);

  // Every data move goes through the adder (addend 0 for non-ADD ops), so the
  // carry-out is naturally 0 for everything except an overflowing ADD.
  always_comb begin
    alu_addend = is_add(op) ? imm : '0;
    case (op)
      OP_ADD_A, OP_MOV_B_A:                alu_src = a_reg;
      OP_ADD_B, OP_MOV_A_B, OP_OUT_B:      alu_src = b_reg;
      OP_IN_A, OP_IN_B:                    alu_src = IN;
      OP_MOV_A_IM, OP_MOV_B_IM, OP_OUT_IM: alu_src = imm;
      default:                             alu_src = '0;
    endcase
  end

  td4_alu #(.DATA_W(DATA_W)) u_alu (
    .src    (alu_src),
    .addend (alu_addend),
    .result (alu_result),
    .carry  (alu_carry)
  );

  always_comb begin
    pc_nxt    = pc;
    a_nxt     = a_reg;
    b_nxt     = b_reg;
    out_nxt   = out_reg;
    carry_nxt = carry_q;
    state_nxt = state;
    if (exec) begin
      carry_nxt = alu_carry;
      pc_nxt    = pc + 1'b1;
      case (op)
        OP_ADD_A, OP_MOV_A_B, OP_IN_A, OP_MOV_A_IM: a_nxt   = alu_result;
        OP_ADD_B, OP_MOV_B_A, OP_IN_B, OP_MOV_B_IM: b_nxt   = alu_result;
        OP_OUT_B, OP_OUT_IM:                        out_nxt = alu_result;
        OP_JMP: pc_nxt = imm[ADDR_W-1:0];
        // Conditional jumps look at the flag left by the previous instruction.
        OP_JNC: if (!carry_q) pc_nxt = imm[ADDR_W-1:0];
        OP_JC:  if (carry_q)  pc_nxt = imm[ADDR_W-1:0];
        OP_HALT: begin
          pc_nxt    = pc;  // A keeps pointing at the HALT word
          state_nxt = ST_HALT;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      pc      <= '0;
      a_reg   <= '0;
      b_reg   <= '0;
      out_reg <= '0;
      carry_q <= 1'b0;
      state   <= ST_RUN;
    end else begin
      pc      <= pc_nxt;
      a_reg   <= a_nxt;
      b_reg   <= b_nxt;
      out_reg <= out_nxt;
      carry_q <= carry_nxt;
      state   <= state_nxt;
    end
  end

  assign A      = pc;
  assign OUT    = out_reg;
  assign CARRY  = carry_q;
  assign HALTED = (state == ST_HALT);

endmodule
